// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the CPU data-memory responder.
// Holds the MMIO window base, register offsets and the byte-lane merge function.
package dmem_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hBFAF;
    localparam logic [15:0] MMIO_LED   = 16'h0000;
    localparam logic [15:0] MMIO_SW    = 16'h0004;
    localparam logic [15:0] MMIO_TIMER = 16'h0008;

    // Replace each byte of old_word whose enable is set with the matching byte of new_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wea);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wea[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_responder_byte_lane_ram.sv
// Single-port word RAM with per-byte write enables and a registered read-first output.
// Storage has no reset so it maps onto block RAM; only the output register clears.
module byte_lane_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_din,
    output logic [31:0]       o_dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
            end
        end
    end

    // Read-first: the word captured here is the one present before this cycle's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (i_en) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: byte-lane data RAM plus an MMIO window holding the
// LED register, synchronised switch inputs and a free-running timer.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [15:0] MMIO_BASE = dmem_pkg::MMIO_BASE,
    parameter int unsigned LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [3:0]       wea,
    input  logic [31:0]      addra,
    input  logic [31:0]      dina,
    output logic [31:0]      douta,
    output logic             ack,
    input  logic [LED_W-1:0] sw,
    output logic [LED_W-1:0] led
);

    logic [15:0]      w_offset;
    logic             w_mmio_sel;
    logic             w_mmio_wr;
    logic             w_ram_en;
    logic [3:0]       w_ram_we;
    logic [31:0]      w_ram_rdata;
    logic [31:0]      w_mmio_rdata;
    logic [31:0]      w_led_merged;
    logic [31:0]      w_timer_merged;
    logic             w_unused;

    logic             r_ack;
    logic             r_sel_mmio;
    logic [31:0]      r_mmio_rdata;
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_timer;
    logic [LED_W-1:0] r_sw_meta;
    logic [LED_W-1:0] r_sw_sync;

    assign w_offset       = {addra[15:2], 2'b00};
    assign w_mmio_sel     = (addra[31:16] == MMIO_BASE);
    assign w_mmio_wr      = ena && w_mmio_sel && (wea != 4'b0000);
    assign w_ram_en       = ena && !w_mmio_sel;
    assign w_ram_we       = (w_ram_en && !rst) ? wea : 4'b0000;
    assign w_led_merged   = lane_merge(32'(r_led), dina, wea);
    assign w_timer_merged = lane_merge(r_timer, dina, wea);
    assign w_unused       = ^{addra[1:0], w_led_merged};

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (addra[ADDR_W+1:2]),
        .i_din  (dina),
        .o_dout (w_ram_rdata)
    );

    // MMIO read mux sees pre-update register values, matching the RAM's read-first behaviour.
    always_comb begin
        w_mmio_rdata = '0;
        case (w_offset)
            MMIO_LED:   w_mmio_rdata = 32'(r_led);
            MMIO_SW:    w_mmio_rdata = 32'(r_sw_sync);
            MMIO_TIMER: w_mmio_rdata = r_timer;
            default:    w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack        <= 1'b0;
            r_sel_mmio   <= 1'b0;
            r_mmio_rdata <= '0;
            r_led        <= '0;
            r_timer      <= '0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
        end else begin
            r_ack     <= ena;
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (ena) begin
                r_sel_mmio <= w_mmio_sel;
                if (w_mmio_sel) r_mmio_rdata <= w_mmio_rdata;
            end
            if (w_mmio_wr && w_offset == MMIO_LED) r_led <= w_led_merged[LED_W-1:0];
            // A load takes the place of that cycle's increment.
            if (w_mmio_wr && w_offset == MMIO_TIMER) r_timer <= w_timer_merged;
            else                                     r_timer <= r_timer + 32'd1;
        end
    end

    assign douta = r_sel_mmio ? r_mmio_rdata : w_ram_rdata;
    assign ack   = r_ack;
    assign led   = r_led;

endmodule
